// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase calculator: default widths, pipeline
// latency, the per-channel configuration record and the phase-offset alignment.
package dds_pkg;

  localparam int DDS_ACC_W      = 48;
  localparam int DDS_PHASE_IN_W = 14;
  localparam int DDS_OUT_W      = 14;
  localparam int MAC_LATENCY    = 4;

  typedef struct packed {
    logic                      en;
    logic                      rel;
    logic [DDS_ACC_W-1:0]      freq;
    logic [DDS_ACC_W-1:0]      offset;
    logic [DDS_PHASE_IN_W-1:0] phase;
    logic [DDS_ACC_W-1:0]      t0;
  } dds_ch_cfg_t;

  // MSB-align a phase offset into the accumulator
  function automatic logic [DDS_ACC_W-1:0] align_phase(input logic [DDS_PHASE_IN_W-1:0] ph);
    return DDS_ACC_W'(ph) << (DDS_ACC_W - DDS_PHASE_IN_W);
  endfunction

endpackage

// File: rtl/dds_phase_mac_lane.sv
// One channel of the phase calculator: offset add, truncated multiply,
// reduction and phase-offset add. Valids come from the top-level pipeline.
// Optional build macro: DDS_PHASE_MAC_ROUND_EN (round half up before truncation).
module dds_phase_mac_lane
  import dds_pkg::*;
#(
  parameter int ACC_W      = DDS_ACC_W,
  parameter int PHASE_IN_W = DDS_PHASE_IN_W,
  parameter int OUT_W      = DDS_OUT_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ts_valid,
  input  logic [ACC_W-1:0]      ts,
  input  dds_ch_cfg_t           cfg,
  input  logic                  vld_p1,
  input  logic                  vld_p2,
  input  logic                  vld_p3,
  output logic [OUT_W-1:0]      phase_out
);

  localparam int NCK    = (ACC_W + 15) / 16;
  localparam int PAD_W  = NCK * 16;
  localparam int RND_SH = (ACC_W > OUT_W) ? (ACC_W - OUT_W - 1) : 0;

  // Take the top OUT_W bits, optionally rounding half up (wraps modulo 2^ACC_W)
  function automatic logic [OUT_W-1:0] round_trunc(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] a;
    a = acc;
`ifdef DDS_PHASE_MAC_ROUND_EN
    if (ACC_W > OUT_W) a = acc + (ACC_W'(1) << RND_SH);
`endif
    return a[ACC_W-1 -: OUT_W];
  endfunction

  logic [ACC_W-1:0]      eff_off_c;
  logic [ACC_W-1:0]      tsum_p1, freq_p1;
  logic [PHASE_IN_W-1:0] phase_p1, phase_p2, phase_p3;
  logic                  en_p1, en_p2, en_p3;
  logic [PAD_W-1:0]      a_pad, b_pad;
  logic [ACC_W-1:0]      pp_c  [NCK*NCK];
  logic [ACC_W-1:0]      pp_p2 [NCK*NCK];
  logic [ACC_W-1:0]      sum_c, sum_p3;

  // Relative mode measures time from the latched reference t0
  assign eff_off_c = cfg.rel ? (ACC_W'(0) - cfg.t0) : cfg.offset;

  // ---- S1: shifted time and config snapshot ----
  always_ff @(posedge clk) begin
    if (ts_valid) begin
      tsum_p1  <= ts + eff_off_c;
      freq_p1  <= cfg.freq;
      phase_p1 <= cfg.phase;
      en_p1    <= cfg.en;
    end
  end

  // 16x16 partial products; those landing at or above bit ACC_W are dropped
  always_comb begin
    a_pad = PAD_W'(tsum_p1);
    b_pad = PAD_W'(freq_p1);
    for (int i = 0; i < NCK; i++) begin
      for (int j = 0; j < NCK; j++) begin
        if ((i + j) * 16 < ACC_W)
          pp_c[i*NCK+j] = ACC_W'(32'(a_pad[i*16 +: 16]) * 32'(b_pad[j*16 +: 16])) << ((i + j) * 16);
        else
          pp_c[i*NCK+j] = '0;
      end
    end
  end

  // ---- S2: partial products ----
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      pp_p2    <= pp_c;
      phase_p2 <= phase_p1;
      en_p2    <= en_p1;
    end
  end

  // Modular reduction of all partial products
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NCK*NCK; k++) sum_c = sum_c + pp_p2[k];
  end

  // ---- S3: reduced product ----
  always_ff @(posedge clk) begin
    if (vld_p2) begin
      sum_p3   <= sum_c;
      phase_p3 <= phase_p2;
      en_p3    <= en_p2;
    end
  end

  // ---- S4: phase offset, truncation, registered output (holds between samples) ----
  always_ff @(posedge clk) begin
    if (!resetn)     phase_out <= '0;
    else if (vld_p3) phase_out <= en_p3 ? round_trunc(sum_p3 + align_phase(phase_p3)) : '0;
  end

endmodule

// File: rtl/dds_phase_mac.sv
// Multi-channel pipelined DDS phase calculator. Owns the per-channel config
// register file, the last accepted timestamp and the valid/timestamp pipeline;
// one dds_phase_mac_lane per channel does the arithmetic.
// Optional build macro: DDS_PHASE_MAC_ROUND_EN (round half up in the last stage).
module dds_phase_mac
  import dds_pkg::*;
#(
  parameter int ACC_W      = DDS_ACC_W,
  parameter int PHASE_IN_W = DDS_PHASE_IN_W,
  parameter int OUT_W      = DDS_OUT_W,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ts_valid,
  input  logic [ACC_W-1:0]        ts,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_en,
  input  logic                    cfg_rel,
  input  logic [ACC_W-1:0]        cfg_freq,
  input  logic [ACC_W-1:0]        cfg_offset,
  input  logic [PHASE_IN_W-1:0]   cfg_phase,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_ts,
  output logic [NUM_CH*OUT_W-1:0] out_phase
);

  localparam bit CH_FULL = ((1 << CH_W) == NUM_CH);

  dds_ch_cfg_t      cfg_q [NUM_CH];
  logic [ACC_W-1:0] last_ts;
  logic [ACC_W-1:0] ref_ts;
  logic             ch_ok;
  logic             vld_p1, vld_p2, vld_p3;
  logic [ACC_W-1:0] ts_p1, ts_p2, ts_p3;

  generate
    if (CH_FULL) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_chk
      assign ch_ok = (cfg_ch < CH_W'(NUM_CH));
    end
  endgenerate

  // A coincident timestamp is the newest time, so it wins as the reference
  assign ref_ts = ts_valid ? ts : last_ts;

  // Config register file and last accepted timestamp
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_CH; k++) cfg_q[k] <= '0;
      last_ts <= '0;
    end else begin
      if (ts_valid) last_ts <= ts;
      if (cfg_we && ch_ok) begin
        cfg_q[cfg_ch].en     <= cfg_en;
        cfg_q[cfg_ch].rel    <= cfg_rel;
        cfg_q[cfg_ch].freq   <= cfg_freq;
        cfg_q[cfg_ch].offset <= cfg_offset;
        cfg_q[cfg_ch].phase  <= cfg_phase;
        if (cfg_rel) cfg_q[cfg_ch].t0 <= ref_ts;
      end
    end
  end

  // Valid shift pipeline; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      vld_p1    <= ts_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
    end
  end

  // ---- S1..S3: timestamp travels with its sample ----
  always_ff @(posedge clk) begin
    if (ts_valid) ts_p1 <= ts;
    if (vld_p1)   ts_p2 <= ts_p1;
    if (vld_p2)   ts_p3 <= ts_p2;
  end

  // ---- S4: registered timestamp output, held between samples ----
  always_ff @(posedge clk) begin
    if (!resetn)     out_ts <= '0;
    else if (vld_p3) out_ts <= ts_p3;
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      dds_phase_mac_lane #(
        .ACC_W      (ACC_W),
        .PHASE_IN_W (PHASE_IN_W),
        .OUT_W      (OUT_W)
      ) u_lane (
        .clk       (clk),
        .resetn    (resetn),
        .ts_valid  (ts_valid),
        .ts        (ts),
        .cfg       (cfg_q[g]),
        .vld_p1    (vld_p1),
        .vld_p2    (vld_p2),
        .vld_p3    (vld_p3),
        .phase_out (out_phase[g*OUT_W +: OUT_W])
      );
    end
  endgenerate

endmodule
